// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package rv_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode; flush empties it in one cycle.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = r_mem[r_rptr];
  assign count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues one imem request at a time from PCout, queues responses for decode.
// Handshakes: imem request transfers on imem_req && imem_gnt; decode transfers on instr_valid && instr_ready.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCout,
  output logic [XLEN-1:0] PCin,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output fetch_state_t    dbg_state
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t    r_state;
  logic            r_imem_req;
  logic [XLEN-1:0] r_req_pc;

  logic [CW-1:0]   w_count;
  logic            w_outstanding;
  logic            w_credit;
  logic            w_credit_after;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_redirect;
  fq_entry_t       w_push_entry;
  fq_entry_t       w_head;

  assign w_redirect     = rst && redirect_valid;
  assign w_outstanding  = (r_state == S_WAIT) || (r_state == S_FLUSH);
  // Counting the outstanding response as occupied guarantees it always finds space.
  assign w_credit       = (w_count + CW'(w_outstanding)) < CW'(QDEPTH);
  assign w_credit_after = (w_count + CW'(1) - CW'(w_pop)) < CW'(QDEPTH);
  assign w_grant        = (r_state == S_REQ) && imem_gnt;
  assign w_push         = (r_state == S_WAIT) && imem_rvalid && !w_redirect;
  assign w_pop          = instr_valid && instr_ready && !w_redirect;

  always_comb begin
    PCin = PCout;
    if (w_redirect)   PCin = {redirect_pc[XLEN-1:2], 2'b00};
    else if (w_grant) PCin = PCout + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_req_pc   <= '0;
    end else if (w_redirect) begin
      r_imem_req <= 1'b0;
      // A response still owed to us must be swallowed before new requests go out.
      if ((r_state == S_REQ && imem_gnt) ||
          ((r_state == S_WAIT || r_state == S_FLUSH) && !imem_rvalid))
        r_state <= S_FLUSH;
      else
        r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_credit) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            r_req_pc   <= PCout;
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state    <= w_credit_after ? S_REQ : S_IDLE;
            r_imem_req <= w_credit_after;
          end
        end
        S_FLUSH: begin
          if (imem_rvalid) r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign w_push_entry = '{instr: imem_rdata, pc: r_req_pc};

  fetch_queue #(
    .W     ($bits(fq_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (w_redirect),
    .head_data (w_head),
    .count     (w_count)
  );

  assign imem_req    = r_imem_req;
  assign imem_addr   = PCout;
  assign instr_valid = (w_count != '0);
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and instruction memory model around the DUT.
module tb_fetch_unit;
  import rv_fetch_pkg::*;

  localparam int QD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  PCout;
  logic [31:0]  PCin;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr_data;
  logic [31:0]  instr_pc;
  fetch_state_t dbg_state;

  fetch_unit #(.QDEPTH(QD)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCout          (PCout),
    .PCin           (PCin),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .dbg_state      (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] popped_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Program-counter register, with a bench-side load for setting start PCs.
  logic        pc_load;
  logic [31:0] pc_load_val;
  always @(posedge clk) begin
    if (pc_load) PCout <= pc_load_val;
    else         PCout <= PCin;
  end

  // Memory responder: data arrives 1 + extra_lat cycles after the grant cycle.
  int          resp_cnt  = 0;
  int          extra_lat = 0;
  logic [31:0] resp_addr = '0;

  always @(negedge clk) begin
    if (!rst) resp_cnt = 0;
    else if (imem_req && imem_gnt) begin
      resp_addr = imem_addr;
      resp_cnt  = 1 + extra_lat;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(resp_addr);
      end
    end
  end

  // Reference model: the decode stream is the sequence of granted addresses
  // whose responses arrived with no redirect between grant and response.
  logic        m_inflight = 1'b0;
  logic        m_killed   = 1'b0;
  logic [31:0] m_addr     = '0;

  always @(negedge clk) begin
    logic [31:0] exp_pcin;
    logic [63:0] tmp;
    if (!rst) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_killed   = 1'b0;
    end else begin
      if (redirect_valid)             exp_pcin = {redirect_pc[31:2], 2'b00};
      else if (imem_req && imem_gnt)  exp_pcin = PCout + 32'd4;
      else                            exp_pcin = PCout;
      check("pcin", PCin, exp_pcin);
      if (imem_req) begin
        check("imem_addr", imem_addr, PCout);
        check("credit", ((exp_q.size() + int'(m_inflight)) < QD) ? 32'd1 : 32'd0, 32'd1);
      end
      check("instr_valid", 32'(instr_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
      if (exp_q.size() != 0) begin
        check("instr_pc", instr_pc, exp_q[0][63:32]);
        check("instr_data", instr_data, exp_q[0][31:0]);
      end
      if (instr_valid && instr_ready && !redirect_valid && exp_q.size() != 0) begin
        tmp = exp_q.pop_front();
        popped_q.push_back(tmp[63:32]);
      end
      if (imem_rvalid && m_inflight) begin
        if (!m_killed && !redirect_valid) exp_q.push_back({m_addr, mem_word(m_addr)});
        m_inflight = 1'b0;
      end
      if (redirect_valid) begin
        exp_q.delete();
        m_killed = 1'b1;
      end
      if (imem_req && imem_gnt) begin
        m_inflight = 1'b1;
        m_addr     = imem_addr;
        m_killed   = redirect_valid;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst         = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = start_pc;
    popped_q.delete();
    step(2);
    pc_load = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic wait_req(input int max, input string name);
    int k = 0;
    while (!imem_req && k < max) begin
      step(1);
      k++;
    end
    check(name, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int max, input string name);
    int k = 0;
    while (!(imem_req && imem_addr == a) && k < max) begin
      step(1);
      k++;
    end
    check(name, 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  task automatic wait_valid(input int max, input string name);
    int k = 0;
    while (!instr_valid && k < max) begin
      step(1);
      k++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    rst            = 1'b0;
    pc_load        = 1'b1;
    pc_load_val    = 32'h0;
    imem_gnt       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;

    // Reset values
    step(3);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data",  instr_data,       32'h0);
    check("rst_ipc",   instr_pc,         32'h0);
    check("rst_pcin",  PCin,             32'h0);
    check("rst_state", 32'(dbg_state),   32'(S_IDLE));

    // Sequential fetch from 0
    instr_ready = 1'b1;
    imem_gnt    = 1'b1;
    extra_lat   = 0;
    do_reset(32'h0);
    step(20);
    check("seq_len", (popped_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    if (popped_q.size() >= 3) begin
      check("seq_pc0", popped_q[0], 32'h0);
      check("seq_pc1", popped_q[1], 32'h4);
      check("seq_pc2", popped_q[2], 32'h8);
    end

    // Backpressure: two fetches fill the queue, then requests stop
    instr_ready = 1'b0;
    do_reset(32'h0);
    step(15);
    check("bp_req",   32'(imem_req),    32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_pc",    instr_pc,         32'h0);
    check("bp_data",  instr_data,       32'hDEAD0000);
    check("bp_pcout", PCout,            32'h8);
    check("bp_pcin",  PCin,             32'h8);
    check("bp_state", 32'(dbg_state),   32'(S_IDLE));
    instr_ready = 1'b1;
    wait_req(10, "bp_resume");
    check("bp_resume_addr", imem_addr, 32'h8);
    step(10);

    // Redirect while waiting for the 0x4 response
    extra_lat = 2;
    do_reset(32'h0);
    wait_req_addr(32'h4, 30, "wr_find_req4");
    step(1);
    check("wr_state", 32'(dbg_state), 32'(S_WAIT));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("wr_pcin", PCin, 32'h100);
    step(1);
    redirect_valid = 1'b0;
    check("wr_flush", 32'(dbg_state), 32'(S_FLUSH));
    wait_valid(40, "wr_valid");
    check("wr_ipc",  instr_pc,   32'h100);
    check("wr_data", instr_data, 32'hDEAD0100);
    step(8);

    // Redirect in the same cycle as the grant
    extra_lat = 0;
    imem_gnt  = 1'b0;
    do_reset(32'h0);
    wait_req(10, "rg_req");
    check("rg_hold_pcin", PCin, 32'h0);
    step(2);
    check("rg_req_stable",  32'(imem_req), 32'd1);
    check("rg_addr_stable", imem_addr,     32'h0);
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("rg_pcin", PCin, 32'h200);
    step(1);
    redirect_valid = 1'b0;
    check("rg_flush", 32'(dbg_state), 32'(S_FLUSH));
    wait_valid(20, "rg_valid");
    check("rg_ipc",  instr_pc,   32'h200);
    check("rg_data", instr_data, 32'hDEAD0200);
    step(6);

    // Wrap at the top of the address space, then a misaligned redirect
    imem_gnt = 1'b0;
    do_reset(32'hFFFF_FFFC);
    wait_req(10, "wrap_req");
    check("wrap_addr",      imem_addr, 32'hFFFF_FFFC);
    check("wrap_hold_pcin", PCin,      32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    #1;
    check("wrap_pcin", PCin, 32'h0);
    step(5);
    check("wrap_first", (popped_q.size() > 0) ? popped_q[0] : 32'h0, 32'hFFFF_FFFC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    check("align_pcin", PCin, 32'h100);
    step(1);
    redirect_valid = 1'b0;
    wait_valid(20, "align_valid");
    check("align_ipc", instr_pc, 32'h100);
    step(6);

    // Asynchronous reset in the middle of a fetch
    instr_ready = 1'b0;
    extra_lat   = 2;
    do_reset(32'h0);
    wait_req_addr(32'h4, 30, "mr_find_req4");
    step(1);
    check("mr_pre_valid", 32'(instr_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mr_req",   32'(imem_req),    32'd0);
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_ipc",   instr_pc,         32'h0);
    check("mr_state", 32'(dbg_state),   32'(S_IDLE));
    step(2);
    rst         = 1'b1;
    instr_ready = 1'b1;
    wait_req(10, "mr_restart");
    check("mr_restart_addr", imem_addr, 32'h8);
    wait_valid(20, "mr_valid_after");
    check("mr_ipc_after", instr_pc, 32'h8);
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer side of the program-counter register: reads the current PC (PCout), fetches the instruction at that address from instruction memory, and returns the next PC (PCin) to the register.
- Buffers fetched instructions with their PCs in a small queue toward decode, using a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding any in-flight response.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- QDEPTH, 2, instruction queue entries (power of two, >=2).
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately; deassertion is synchronous to clk upstream).
- PCout  input  XLEN  current PC from the program-counter register.
- PCin  output  XLEN  next PC to the program-counter register (combinational).
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; equals PCout.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  XLEN  fetched instruction.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  XLEN  redirect target.
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decode accepts head.
- instr_data  output  XLEN  head instruction.
- instr_pc  output  XLEN  PC of head instruction.

Behaviour:
- Reset (rst=0):
  - FSM=IDLE, queue count=0, pointers=0, req_pc=0.
  - imem_req=0, instr_valid=0, instr_data=0, instr_pc=0.
  - PCin=PCout, so the register holds.
- FSM states: IDLE, REQ, WAIT, FLUSH. At most one request is outstanding.
- Credit rule: a new request may be issued only if count + outstanding < QDEPTH. This guarantees every enqueue has space.
- IDLE:
  - imem_req=0.
  - Go to REQ the next cycle when credit is available and redirect_valid=0.
- REQ:
  - imem_req=1, imem_addr=PCout.
  - On imem_gnt: latch req_pc=PCout, set PCin=PCout+PC_STEP (mod 2^XLEN, wraps at 0xFFFFFFFC->0), go to WAIT.
  - Without gnt: hold PCin=PCout and stay in REQ; the request stays asserted and stable.
- WAIT:
  - imem_rvalid may arrive at the earliest 1 cycle after gnt.
  - On rvalid: enqueue {imem_rdata, req_pc}.
  - Next state is REQ if credit remains after the enqueue, otherwise IDLE.
- FLUSH:
  - Wait for the discarded in-flight response. rvalid is consumed and not enqueued.
  - Then go to IDLE (REQ next cycle if credit is available).
- Redirect (highest priority, any state):
  - PCin=redirect_pc with bits[1:0] forced to 0.
  - Queue emptied: count=0, pointers reset, instr_valid=0 next cycle.
  - If in WAIT, or in REQ with gnt in the same cycle, go to FLUSH.
  - If in WAIT with rvalid in the same cycle, that response is dropped and the next state is IDLE.
  - Otherwise go to IDLE.
  - A pending ungranted request is withdrawn.
- Queue:
  - instr_valid = (count != 0); head data is stable while instr_valid=1 and instr_ready=0.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Dequeue on instr_valid && instr_ready.
  - Redirect overrides any same-cycle dequeue.
- PCin default in all other cycles: PCout (register holds).

Decomposition:
- Shared package rv_fetch_pkg:
  - FSM state typedef (IDLE/REQ/WAIT/FLUSH).
  - XLEN and PC_STEP constants.
  - Fetch queue entry typedef {instr, pc}.
- One sub-module, fetch_queue: parameterised synchronous FIFO (QDEPTH entries, push/pop/flush, count output, asynchronous active-low reset).

Test Plan:
- Reset sequential fetch: PCout=0 loop through the register, gnt=1 every REQ, rvalid 1 cycle later, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, ...; instr_data matches memory; PCin steps by 4 only on gnt cycles.
- Backpressure: instr_ready=0 -> after 2 fetches imem_req=0 and count=2; PCin=PCout (held); head at 0x0 stable. Raising instr_ready resumes fetching at 0x8.
- Redirect while in WAIT: redirect_pc=0x100 -> PCin=0x100; next rvalid (PC 0x4 data) not enqueued; next instr_pc=0x100.
- Redirect with simultaneous gnt: the granted response is discarded; PCin=redirect target; no stale instruction appears at the output.
- Wrap and alignment: PCout=0xFFFFFFFC -> PCin=0x0 on gnt; redirect_pc=0x103 -> PCin=0x100.
- Mid-operation reset: rst=0 during WAIT -> imem_req=0 and instr_valid=0 immediately; after release, fetch restarts from the current PCout.
